// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and the rd-match helper for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN,
        MC_BUSY
    } hz_state_e;

    // x0 is never a real producer, so a write to it can't create a dependency
    function automatic logic rd_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != '1)
            q <= q + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding control for the 5-stage RV32I core,
// with a multi-cycle EX stall FSM and saturating stall/flush counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit FWD_EN    = 1'b0,
    parameter bit WB_BYPASS = 1'b1,
    parameter int LAT_W     = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcsel_exmem,
    input  logic             is_br_exmem,
    input  logic             is_uncbr_exmem,
    input  logic [4:0]       rs1_ifid,
    input  logic [4:0]       rs2_ifid,
    input  logic [4:0]       rs1_idex,
    input  logic [4:0]       rs2_idex,
    input  logic             rdwren_idex,
    input  logic [4:0]       rd_idex,
    input  logic             memrd_idex,
    input  logic             rdwren_exmem,
    input  logic [4:0]       rd_exmem,
    input  logic             memrd_exmem,
    input  logic             rdwren_memwb,
    input  logic [4:0]       rd_memwb,
    input  logic             mc_start_idex,
    input  logic [LAT_W-1:0] mc_lat,
    output logic             pc_wren,
    output logic             wren_ifid,
    output logic             wren_idex,
    output logic             clear_ifid,
    output logic             clear_idex,
    output logic             clear_exmem,
    output fwd_sel_e         fwd_a_sel,
    output fwd_sel_e         fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e        state, state_nxt;
    logic [LAT_W-1:0] busy, busy_nxt;
    logic             redirect, mc_go, raw;
    logic             hit_idex, hit_exmem, hit_memwb;
    logic             a_ex, a_wb, b_ex, b_wb;

    assign redirect = pcsel_exmem & (is_br_exmem | is_uncbr_exmem);
    assign mc_go    = mc_start_idex && (mc_lat >= LAT_W'(2));

    assign hit_idex  = rd_hit(rdwren_idex, rd_idex, rs1_ifid) | rd_hit(rdwren_idex, rd_idex, rs2_ifid);
    assign hit_exmem = rd_hit(rdwren_exmem, rd_exmem, rs1_ifid) | rd_hit(rdwren_exmem, rd_exmem, rs2_ifid);
    assign hit_memwb = rd_hit(rdwren_memwb, rd_memwb, rs1_ifid) | rd_hit(rdwren_memwb, rd_memwb, rs2_ifid);
    assign raw = FWD_EN ? (memrd_idex & hit_idex)
                        : (hit_idex | hit_exmem | (!WB_BYPASS & hit_memwb));

    // a load in EX/MEM has no data yet, so it falls through to the older MEM/WB producer
    assign a_ex = rd_hit(rdwren_exmem, rd_exmem, rs1_idex) && !memrd_exmem;
    assign b_ex = rd_hit(rdwren_exmem, rd_exmem, rs2_idex) && !memrd_exmem;
    assign a_wb = rd_hit(rdwren_memwb, rd_memwb, rs1_idex);
    assign b_wb = rd_hit(rdwren_memwb, rd_memwb, rs2_idex);
    assign fwd_a_sel = (!FWD_EN || rst) ? FWD_NONE : a_ex ? FWD_EXMEM : a_wb ? FWD_MEMWB : FWD_NONE;
    assign fwd_b_sel = (!FWD_EN || rst) ? FWD_NONE : b_ex ? FWD_EXMEM : b_wb ? FWD_MEMWB : FWD_NONE;

    always_comb begin
        state_nxt   = state;
        busy_nxt    = busy;
        pc_wren     = 1'b1;
        wren_ifid   = 1'b1;
        wren_idex   = 1'b1;
        clear_ifid  = 1'b0;
        clear_idex  = 1'b0;
        clear_exmem = 1'b0;
        if (rst) begin
            state_nxt = RUN;
            busy_nxt  = '0;
        end else if (redirect) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
            state_nxt   = RUN;
            busy_nxt    = '0;
        end else if (state == MC_BUSY) begin
            pc_wren     = 1'b0;
            wren_ifid   = 1'b0;
            wren_idex   = 1'b0;
            clear_exmem = 1'b1;
            busy_nxt    = (busy == '0) ? '0 : busy - LAT_W'(1);
            state_nxt   = (busy == '0) ? RUN : MC_BUSY;
        end else if (mc_go) begin
            state_nxt = MC_BUSY;
            busy_nxt  = mc_lat - LAT_W'(2);
        end else if (raw) begin
            pc_wren    = 1'b0;
            wren_ifid  = 1'b0;
            clear_idex = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!pc_wren),
        .clr (1'b0),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect),
        .clr (1'b0),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three parameterisations of hazard_ctrl checked every cycle against a
// rule-level model, plus directed literal checks
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pcsel_exmem, is_br_exmem, is_uncbr_exmem;
    logic rdwren_idex, memrd_idex, rdwren_exmem, memrd_exmem, rdwren_memwb, mc_start_idex;
    logic [4:0] rs1_ifid, rs2_ifid, rs1_idex, rs2_idex, rd_idex, rd_exmem, rd_memwb;
    logic [3:0] mc_lat;

    logic pc_wren[3], wren_ifid[3], wren_idex[3], clear_ifid[3], clear_idex[3], clear_exmem[3];
    fwd_sel_e fa[3], fb[3];
    logic [3:0]  sc0, fc0;
    logic [31:0] sc1, fc1;
    logic [7:0]  sc2, fc2;
    logic [31:0] sc[3], fc[3];
    assign sc[0] = 32'(sc0);
    assign sc[1] = sc1;
    assign sc[2] = 32'(sc2);
    assign fc[0] = 32'(fc0);
    assign fc[1] = fc1;
    assign fc[2] = 32'(fc2);

    // d0: no forwarding, write-through regfile, 4-bit counters
    // d1: forwarding, 32-bit counters
    // d2: no forwarding, no write-through, 8-bit counters
    localparam bit    FW[3] = '{1'b0, 1'b1, 1'b0};
    localparam bit    WB[3] = '{1'b1, 1'b1, 1'b0};
    localparam longint MX[3] = '{64'd15, 64'hFFFF_FFFF, 64'd255};

    hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b1), .LAT_W(4), .CNT_W(4)) d0 (
        .clk(clk), .rst(rst), .pcsel_exmem(pcsel_exmem), .is_br_exmem(is_br_exmem),
        .is_uncbr_exmem(is_uncbr_exmem), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
        .rs1_idex(rs1_idex), .rs2_idex(rs2_idex), .rdwren_idex(rdwren_idex), .rd_idex(rd_idex),
        .memrd_idex(memrd_idex), .rdwren_exmem(rdwren_exmem), .rd_exmem(rd_exmem),
        .memrd_exmem(memrd_exmem), .rdwren_memwb(rdwren_memwb), .rd_memwb(rd_memwb),
        .mc_start_idex(mc_start_idex), .mc_lat(mc_lat), .pc_wren(pc_wren[0]),
        .wren_ifid(wren_ifid[0]), .wren_idex(wren_idex[0]), .clear_ifid(clear_ifid[0]),
        .clear_idex(clear_idex[0]), .clear_exmem(clear_exmem[0]), .fwd_a_sel(fa[0]),
        .fwd_b_sel(fb[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl #(.FWD_EN(1'b1), .WB_BYPASS(1'b1), .LAT_W(4), .CNT_W(32)) d1 (
        .clk(clk), .rst(rst), .pcsel_exmem(pcsel_exmem), .is_br_exmem(is_br_exmem),
        .is_uncbr_exmem(is_uncbr_exmem), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
        .rs1_idex(rs1_idex), .rs2_idex(rs2_idex), .rdwren_idex(rdwren_idex), .rd_idex(rd_idex),
        .memrd_idex(memrd_idex), .rdwren_exmem(rdwren_exmem), .rd_exmem(rd_exmem),
        .memrd_exmem(memrd_exmem), .rdwren_memwb(rdwren_memwb), .rd_memwb(rd_memwb),
        .mc_start_idex(mc_start_idex), .mc_lat(mc_lat), .pc_wren(pc_wren[1]),
        .wren_ifid(wren_ifid[1]), .wren_idex(wren_idex[1]), .clear_ifid(clear_ifid[1]),
        .clear_idex(clear_idex[1]), .clear_exmem(clear_exmem[1]), .fwd_a_sel(fa[1]),
        .fwd_b_sel(fb[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b0), .LAT_W(4), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .pcsel_exmem(pcsel_exmem), .is_br_exmem(is_br_exmem),
        .is_uncbr_exmem(is_uncbr_exmem), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
        .rs1_idex(rs1_idex), .rs2_idex(rs2_idex), .rdwren_idex(rdwren_idex), .rd_idex(rd_idex),
        .memrd_idex(memrd_idex), .rdwren_exmem(rdwren_exmem), .rd_exmem(rd_exmem),
        .memrd_exmem(memrd_exmem), .rdwren_memwb(rdwren_memwb), .rd_memwb(rd_memwb),
        .mc_start_idex(mc_start_idex), .mc_lat(mc_lat), .pc_wren(pc_wren[2]),
        .wren_ifid(wren_ifid[2]), .wren_idex(wren_idex[2]), .clear_ifid(clear_ifid[2]),
        .clear_idex(clear_idex[2]), .clear_exmem(clear_exmem[2]), .fwd_a_sel(fa[2]),
        .fwd_b_sel(fb[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && rd != 0 && rd == rs;
    endfunction

    // model: remaining stall cycles of the multi-cycle op, and the two event tallies
    int     rem[3] = '{0, 0, 0};
    longint ms[3]  = '{0, 0, 0};
    longint mf[3]  = '{0, 0, 0};

    function automatic int fsel(input int i, input logic [4:0] rs);
        if (rst || !FW[i]) return 0;
        if (hit(rdwren_exmem, rd_exmem, rs) && !memrd_exmem) return 1;
        if (hit(rdwren_memwb, rd_memwb, rs)) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit r, go, raw, stall;
        int k;
        if (run_chk) begin
            r  = pcsel_exmem & (is_br_exmem | is_uncbr_exmem);
            go = mc_start_idex && mc_lat >= 2;
            for (int i = 0; i < 3; i++) begin
                if (FW[i])
                    raw = memrd_idex && (hit(rdwren_idex, rd_idex, rs1_ifid) || hit(rdwren_idex, rd_idex, rs2_ifid));
                else
                    raw = hit(rdwren_idex, rd_idex, rs1_ifid) || hit(rdwren_idex, rd_idex, rs2_ifid)
                       || hit(rdwren_exmem, rd_exmem, rs1_ifid) || hit(rdwren_exmem, rd_exmem, rs2_ifid)
                       || (!WB[i] && (hit(rdwren_memwb, rd_memwb, rs1_ifid) || hit(rdwren_memwb, rd_memwb, rs2_ifid)));
                // 0 normal, 1 redirect, 2 multi-cycle bubble, 3 RAW stall
                k = rst ? 0 : r ? 1 : rem[i] > 0 ? 2 : go ? 0 : raw ? 3 : 0;
                stall = (k == 2) || (k == 3);
                chk($sformatf("d%0d pc_wren", i), pc_wren[i], !stall);
                chk($sformatf("d%0d wren_ifid", i), wren_ifid[i], !stall);
                chk($sformatf("d%0d wren_idex", i), wren_idex[i], k != 2);
                chk($sformatf("d%0d clear_ifid", i), clear_ifid[i], k == 1);
                chk($sformatf("d%0d clear_idex", i), clear_idex[i], k == 1 || k == 3);
                chk($sformatf("d%0d clear_exmem", i), clear_exmem[i], k == 1 || k == 2);
                chk($sformatf("d%0d fwd_a_sel", i), fa[i], fsel(i, rs1_idex));
                chk($sformatf("d%0d fwd_b_sel", i), fb[i], fsel(i, rs2_idex));
                chk($sformatf("d%0d stall_cnt", i), sc[i], rst ? 0 : ms[i]);
                chk($sformatf("d%0d flush_cnt", i), fc[i], rst ? 0 : mf[i]);
                if (rst) begin
                    rem[i] = 0;
                    ms[i]  = 0;
                    mf[i]  = 0;
                end else begin
                    if (stall && ms[i] < MX[i]) ms[i]++;
                    if (r && mf[i] < MX[i]) mf[i]++;
                    rem[i] = r ? 0 : rem[i] > 0 ? rem[i] - 1 : go ? int'(mc_lat) - 1 : 0;
                end
            end
        end
    end

    task automatic idle();
        pcsel_exmem = 0; is_br_exmem = 0; is_uncbr_exmem = 0;
        rdwren_idex = 0; memrd_idex = 0; rdwren_exmem = 0; memrd_exmem = 0; rdwren_memwb = 0;
        mc_start_idex = 0; mc_lat = 0;
        rs1_ifid = 0; rs2_ifid = 0; rs1_idex = 0; rs2_idex = 0;
        rd_idex = 0; rd_exmem = 0; rd_memwb = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        idle();
        #1 rst = 1'b1;
        run_chk = 1'b1;
        #2;
        chk("reset pc_wren", pc_wren[0], 1);
        chk("reset clear_idex", clear_idex[0], 0);
        chk("reset stall_cnt", sc[0], 0);
        chk("reset fwd_a", fa[1], FWD_NONE);
        repeat (2) @(negedge clk);
        step(); rst = 1'b0;

        step(); rdwren_exmem = 1; rd_exmem = 12; rs2_ifid = 12;
        @(negedge clk);
        chk("raw d0 pc_wren", pc_wren[0], 0);
        chk("raw d0 wren_ifid", wren_ifid[0], 0);
        chk("raw d0 clear_idex", clear_idex[0], 1);
        chk("raw d1 no stall", pc_wren[1], 1);
        step(); rd_exmem = 0; rs2_ifid = 0;
        @(negedge clk);
        chk("x0 d0 no stall", pc_wren[0], 1);
        chk("raw d0 stall_cnt", sc[0], 1);

        step(); idle(); rdwren_idex = 1; memrd_idex = 1; rd_idex = 5; rs1_ifid = 5;
        @(negedge clk);
        chk("load-use d1 pc_wren", pc_wren[1], 0);
        chk("load-use d1 clear_idex", clear_idex[1], 1);
        step(); memrd_idex = 0;
        @(negedge clk);
        chk("non-load d1 pc_wren", pc_wren[1], 1);
        chk("load-use d1 stall_cnt", sc[1], 1);

        step(); idle(); rdwren_exmem = 1; rdwren_memwb = 1; rd_exmem = 7; rd_memwb = 7; rs1_idex = 7;
        @(negedge clk);
        chk("fwd d1 exmem", fa[1], FWD_EXMEM);
        chk("fwd d0 none", fa[0], FWD_NONE);
        step(); memrd_exmem = 1;
        @(negedge clk);
        chk("fwd d1 memwb", fa[1], FWD_MEMWB);

        step(); idle(); mc_start_idex = 1; mc_lat = 4;
        @(negedge clk);
        chk("mc start no stall", pc_wren[1], 1);
        n = 0;
        repeat (6) begin
            step(); idle();
            @(negedge clk);
            if (!pc_wren[1] && clear_exmem[1]) n++;
        end
        chk("mc lat4 bubbles", n, 3);
        chk("mc back to run", pc_wren[1], 1);
        step(); mc_start_idex = 1; mc_lat = 1;
        step(); idle();
        @(negedge clk);
        chk("mc lat1 no stall", pc_wren[1], 1);

        step(); mc_start_idex = 1; mc_lat = 8;
        step(); idle();
        @(negedge clk);
        chk("mc busy pc_wren", pc_wren[1], 0);
        step(); pcsel_exmem = 1; is_br_exmem = 1;
        @(negedge clk);
        chk("redir clear_ifid", clear_ifid[1], 1);
        chk("redir clear_idex", clear_idex[1], 1);
        chk("redir clear_exmem", clear_exmem[1], 1);
        chk("redir pc_wren", pc_wren[1], 1);
        step(); idle();
        @(negedge clk);
        chk("post-redir run", pc_wren[1], 1);
        chk("post-redir clear_exmem", clear_exmem[1], 0);
        chk("redir flush_cnt", fc[1], 1);

        step(); rdwren_exmem = 1; rd_exmem = 12; rs2_ifid = 12;
        repeat (20) step();
        @(negedge clk);
        chk("sat stall_cnt", sc[0], 15);

        step(); idle(); mc_start_idex = 1; mc_lat = 10;
        step(); idle();
        step(); rst = 1'b1;
        #1;
        chk("rst busy pc_wren", pc_wren[1], 1);
        chk("rst busy clear_exmem", clear_exmem[1], 0);
        chk("rst stall_cnt", sc[0], 0);
        chk("rst flush_cnt", fc[1], 0);
        step(); rst = 1'b0;

        repeat (3000) begin
            step();
            pcsel_exmem    = ($urandom_range(0, 5) == 0);
            is_br_exmem    = 1'($urandom);
            is_uncbr_exmem = 1'($urandom);
            rdwren_idex    = 1'($urandom);
            memrd_idex     = 1'($urandom);
            rdwren_exmem   = 1'($urandom);
            memrd_exmem    = 1'($urandom);
            rdwren_memwb   = 1'($urandom);
            mc_start_idex  = ($urandom_range(0, 7) == 0);
            mc_lat         = 4'($urandom_range(0, 15));
            rs1_ifid = 5'($urandom_range(0, 3));
            rs2_ifid = 5'($urandom_range(0, 3));
            rs1_idex = 5'($urandom_range(0, 3));
            rs2_idex = 5'($urandom_range(0, 3));
            rd_idex  = 5'($urandom_range(0, 3));
            rd_exmem = 5'($urandom_range(0, 3));
            rd_memwb = 5'($urandom_range(0, 3));
            rst      = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
